// File: rtl/csr_file_if.sv
// CSR access bundle between the execute/memory pipeline and the machine-mode CSR file.
// Signal names keep the pipeline's established _i/_o naming as seen from the CSR file.
interface csr_file_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CSR_ADDR_WIDTH = 12
);
  logic                      csr_re_i;
  logic [CSR_ADDR_WIDTH-1:0] csr_raddr_i;
  logic [DATA_WIDTH-1:0]     csr_rdata_o;
  logic                      csr_illegal_o;
  logic                      csr_we_i;
  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_i;
  logic [DATA_WIDTH-1:0]     csr_wdata_i;
  logic                      inst_retire_i;
  logic                      exception_i;
  logic [DATA_WIDTH-1:0]     exception_cause_i;
  logic [DATA_WIDTH-1:0]     exception_pc_i;
  logic                      mret_i;
  logic [DATA_WIDTH-1:0]     trap_vector_o;
  logic [DATA_WIDTH-1:0]     mepc_o;
  logic                      mie_global_o;

  // Pipeline side: issues reads, writes and trap events.
  modport master (
    output csr_re_i, csr_raddr_i, csr_we_i, csr_waddr_i, csr_wdata_i,
           inst_retire_i, exception_i, exception_cause_i, exception_pc_i, mret_i,
    input  csr_rdata_o, csr_illegal_o, trap_vector_o, mepc_o, mie_global_o
  );

  // CSR file side.
  modport slave (
    input  csr_re_i, csr_raddr_i, csr_we_i, csr_waddr_i, csr_wdata_i,
           inst_retire_i, exception_i, exception_cause_i, exception_pc_i, mret_i,
    output csr_rdata_o, csr_illegal_o, trap_vector_o, mepc_o, mie_global_o
  );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32IM core: combinational reads, clocked writes,
// 64-bit cycle/instret counters and trap-entry / mret side effects.
module csr_file #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CSR_ADDR_WIDTH = 12,
  parameter logic [31:0] MTVEC_RESET    = 32'h0000_0000,
  parameter int unsigned HART_ID        = 0
) (
  input logic       clk_i,
  input logic       rst_ni,
  csr_file_if.slave bus
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [DATA_WIDTH-1:0] MISA_VALUE = 32'h4000_1100;
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic                  mstatus_mie_reg;
  logic                  mstatus_mpie_reg;
  logic                  mie_msie_reg;
  logic                  mie_mtie_reg;
  logic                  mie_meie_reg;
  logic [DATA_WIDTH-1:0] mtvec_reg;
  logic [DATA_WIDTH-1:0] mscratch_reg;
  logic [DATA_WIDTH-1:0] mepc_reg;
  logic [DATA_WIDTH-1:0] mcause_reg;
  logic [63:0]           mcycle_reg;
  logic [63:0]           mcycle_next;
  logic [63:0]           minstret_reg;
  logic [63:0]           minstret_next;

  logic                  read_hit;
  logic                  trap_event;
  logic                  wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause;
  logic                  wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;

  // A trap or mret owns mstatus/mepc/mcause this cycle; software writes to them lose.
  assign trap_event   = bus.exception_i | bus.mret_i;

  assign wr_mstatus   = bus.csr_we_i && (bus.csr_waddr_i == A_MSTATUS);
  assign wr_mie       = bus.csr_we_i && (bus.csr_waddr_i == A_MIE);
  assign wr_mtvec     = bus.csr_we_i && (bus.csr_waddr_i == A_MTVEC);
  assign wr_mscratch  = bus.csr_we_i && (bus.csr_waddr_i == A_MSCRATCH);
  assign wr_mepc      = bus.csr_we_i && (bus.csr_waddr_i == A_MEPC);
  assign wr_mcause    = bus.csr_we_i && (bus.csr_waddr_i == A_MCAUSE);
  assign wr_mcycle    = bus.csr_we_i && (bus.csr_waddr_i == A_MCYCLE);
  assign wr_mcycleh   = bus.csr_we_i && (bus.csr_waddr_i == A_MCYCLEH);
  assign wr_minstret  = bus.csr_we_i && (bus.csr_waddr_i == A_MINSTRET);
  assign wr_minstreth = bus.csr_we_i && (bus.csr_waddr_i == A_MINSTRETH);

  // Counter next values: a low-half write suppresses the carry, a high-half write
  // replaces the high word while the low word still counts (its carry is lost).
  always_comb begin
    mcycle_next = mcycle_reg + 64'd1;
    if (wr_mcycle) begin
      mcycle_next = {mcycle_reg[63:32], bus.csr_wdata_i};
    end else if (wr_mcycleh) begin
      mcycle_next = {bus.csr_wdata_i, mcycle_reg[31:0] + 32'd1};
    end

    minstret_next = minstret_reg + {63'd0, bus.inst_retire_i};
    if (wr_minstret) begin
      minstret_next = {minstret_reg[63:32], bus.csr_wdata_i};
    end else if (wr_minstreth) begin
      minstret_next = {bus.csr_wdata_i, minstret_reg[31:0] + {31'd0, bus.inst_retire_i}};
    end
  end

  // Read mux: state as of the last edge, no bypass of the write port.
  always_comb begin
    bus.csr_rdata_o = '0;
    read_hit        = 1'b1;
    unique case (bus.csr_raddr_i)
      A_MSTATUS:            bus.csr_rdata_o = {19'd0, 2'b11, 3'd0, mstatus_mpie_reg, 3'd0, mstatus_mie_reg, 3'd0};
      A_MISA:               bus.csr_rdata_o = MISA_VALUE;
      A_MIE:                bus.csr_rdata_o = {20'd0, mie_meie_reg, 3'd0, mie_mtie_reg, 3'd0, mie_msie_reg, 3'd0};
      A_MTVEC:              bus.csr_rdata_o = mtvec_reg;
      A_MSCRATCH:           bus.csr_rdata_o = mscratch_reg;
      A_MEPC:               bus.csr_rdata_o = mepc_reg;
      A_MCAUSE:             bus.csr_rdata_o = mcause_reg;
      A_MCYCLE, A_CYCLE:    bus.csr_rdata_o = mcycle_reg[31:0];
      A_MCYCLEH, A_CYCLEH:  bus.csr_rdata_o = mcycle_reg[63:32];
      A_MINSTRET, A_INSTRET:   bus.csr_rdata_o = minstret_reg[31:0];
      A_MINSTRETH, A_INSTRETH: bus.csr_rdata_o = minstret_reg[63:32];
      A_MHARTID:            bus.csr_rdata_o = DATA_WIDTH'(HART_ID);
      default:              read_hit = 1'b0;
    endcase
  end

  assign bus.csr_illegal_o = bus.csr_re_i & ~read_hit;
  assign bus.trap_vector_o = mtvec_reg;
  assign bus.mepc_o        = mepc_reg;
  assign bus.mie_global_o  = mstatus_mie_reg;

  // Register state: counters, software writes, trap entry and mret.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mstatus_mie_reg  <= 1'b0;
      mstatus_mpie_reg <= 1'b0;
      mie_msie_reg     <= 1'b0;
      mie_mtie_reg     <= 1'b0;
      mie_meie_reg     <= 1'b0;
      mtvec_reg        <= MTVEC_RESET & ALIGN_MASK;
      mscratch_reg     <= '0;
      mepc_reg         <= '0;
      mcause_reg       <= '0;
      mcycle_reg       <= '0;
      minstret_reg     <= '0;
    end else begin
      mcycle_reg   <= mcycle_next;
      minstret_reg <= minstret_next;

      if (bus.exception_i) begin
        mstatus_mpie_reg <= mstatus_mie_reg;
        mstatus_mie_reg  <= 1'b0;
        mepc_reg         <= bus.exception_pc_i & ALIGN_MASK;
        mcause_reg       <= bus.exception_cause_i;
      end else if (bus.mret_i) begin
        mstatus_mie_reg  <= mstatus_mpie_reg;
        mstatus_mpie_reg <= 1'b1;
      end

      if (wr_mstatus && !trap_event) begin
        mstatus_mie_reg  <= bus.csr_wdata_i[3];
        mstatus_mpie_reg <= bus.csr_wdata_i[7];
      end
      if (wr_mepc && !trap_event) begin
        mepc_reg <= bus.csr_wdata_i & ALIGN_MASK;
      end
      if (wr_mcause && !trap_event) begin
        mcause_reg <= bus.csr_wdata_i;
      end

      if (wr_mie) begin
        mie_msie_reg <= bus.csr_wdata_i[3];
        mie_mtie_reg <= bus.csr_wdata_i[7];
        mie_meie_reg <= bus.csr_wdata_i[11];
      end
      if (wr_mtvec) begin
        mtvec_reg <= bus.csr_wdata_i & ALIGN_MASK;
      end
      if (wr_mscratch) begin
        mscratch_reg <= bus.csr_wdata_i;
      end
    end
  end

endmodule
